// File: rtl/ycr1_tap_pkg.sv
// ycr1_tap_pkg
// Shared definitions for the JTAG TAP controller front-end:
//   - type_ycr1_tap_state_e : the 16 IEEE 1149.1 TAP states (4-bit encoding)
//   - YCR1_TAP_INSTR_*      : instruction register opcodes
//   - YCR1_DBG_DMI_CH_ID_*  : chain identifiers reported to the DMI
package ycr1_tap_pkg;

  localparam int          YCR1_TAP_IR_WIDTH       = 5;
  localparam logic [31:0] YCR1_TAP_IDCODE_DEFAULT = 32'hDEB01001;

  typedef enum logic [3:0] {
    YCR1_TAP_STATE_TLR      = 4'd0,
    YCR1_TAP_STATE_RTI      = 4'd1,
    YCR1_TAP_STATE_SEL_DR   = 4'd2,
    YCR1_TAP_STATE_CAP_DR   = 4'd3,
    YCR1_TAP_STATE_SHIFT_DR = 4'd4,
    YCR1_TAP_STATE_EXIT1_DR = 4'd5,
    YCR1_TAP_STATE_PAUSE_DR = 4'd6,
    YCR1_TAP_STATE_EXIT2_DR = 4'd7,
    YCR1_TAP_STATE_UPD_DR   = 4'd8,
    YCR1_TAP_STATE_SEL_IR   = 4'd9,
    YCR1_TAP_STATE_CAP_IR   = 4'd10,
    YCR1_TAP_STATE_SHIFT_IR = 4'd11,
    YCR1_TAP_STATE_EXIT1_IR = 4'd12,
    YCR1_TAP_STATE_PAUSE_IR = 4'd13,
    YCR1_TAP_STATE_EXIT2_IR = 4'd14,
    YCR1_TAP_STATE_UPD_IR   = 4'd15
  } type_ycr1_tap_state_e;

  localparam logic [YCR1_TAP_IR_WIDTH-1:0] YCR1_TAP_INSTR_IDCODE     = 5'h01;
  localparam logic [YCR1_TAP_IR_WIDTH-1:0] YCR1_TAP_INSTR_DTMCS      = 5'h10;
  localparam logic [YCR1_TAP_IR_WIDTH-1:0] YCR1_TAP_INSTR_DMI_ACCESS = 5'h11;
  localparam logic [YCR1_TAP_IR_WIDTH-1:0] YCR1_TAP_INSTR_BYPASS     = 5'h1F;

  localparam logic [1:0] YCR1_DBG_DMI_CH_ID_DTMCS = 2'd1;
  localparam logic [1:0] YCR1_DBG_DMI_CH_ID_DMI   = 2'd2;

endpackage

// File: rtl/ycr1_tap_fsm_core.sv
// ycr1_tap_fsm_core
// Bare IEEE 1149.1 TAP state machine: state register plus next-state logic.
// Ports:
//   clk   - core clock
//   rst   - synchronous active-high reset, returns to Test-Logic-Reset
//   adv   - advance strobe (one clk per TCK rising edge)
//   tms   - TMS value, sampled only when adv=1
//   state - current TAP state (type_ycr1_tap_state_e encoding)
module ycr1_tap_fsm_core
  import ycr1_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic       tms,
  output logic [3:0] state
);

  type_ycr1_tap_state_e state_q;
  type_ycr1_tap_state_e state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= YCR1_TAP_STATE_TLR;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    if (adv) begin
      case (state_q)
        YCR1_TAP_STATE_TLR:      state_next = tms ? YCR1_TAP_STATE_TLR      : YCR1_TAP_STATE_RTI;
        YCR1_TAP_STATE_RTI:      state_next = tms ? YCR1_TAP_STATE_SEL_DR   : YCR1_TAP_STATE_RTI;
        YCR1_TAP_STATE_SEL_DR:   state_next = tms ? YCR1_TAP_STATE_SEL_IR   : YCR1_TAP_STATE_CAP_DR;
        YCR1_TAP_STATE_CAP_DR:   state_next = tms ? YCR1_TAP_STATE_EXIT1_DR : YCR1_TAP_STATE_SHIFT_DR;
        YCR1_TAP_STATE_SHIFT_DR: state_next = tms ? YCR1_TAP_STATE_EXIT1_DR : YCR1_TAP_STATE_SHIFT_DR;
        YCR1_TAP_STATE_EXIT1_DR: state_next = tms ? YCR1_TAP_STATE_UPD_DR   : YCR1_TAP_STATE_PAUSE_DR;
        YCR1_TAP_STATE_PAUSE_DR: state_next = tms ? YCR1_TAP_STATE_EXIT2_DR : YCR1_TAP_STATE_PAUSE_DR;
        YCR1_TAP_STATE_EXIT2_DR: state_next = tms ? YCR1_TAP_STATE_UPD_DR   : YCR1_TAP_STATE_SHIFT_DR;
        YCR1_TAP_STATE_UPD_DR:   state_next = tms ? YCR1_TAP_STATE_SEL_DR   : YCR1_TAP_STATE_RTI;
        YCR1_TAP_STATE_SEL_IR:   state_next = tms ? YCR1_TAP_STATE_TLR      : YCR1_TAP_STATE_CAP_IR;
        YCR1_TAP_STATE_CAP_IR:   state_next = tms ? YCR1_TAP_STATE_EXIT1_IR : YCR1_TAP_STATE_SHIFT_IR;
        YCR1_TAP_STATE_SHIFT_IR: state_next = tms ? YCR1_TAP_STATE_EXIT1_IR : YCR1_TAP_STATE_SHIFT_IR;
        YCR1_TAP_STATE_EXIT1_IR: state_next = tms ? YCR1_TAP_STATE_UPD_IR   : YCR1_TAP_STATE_PAUSE_IR;
        YCR1_TAP_STATE_PAUSE_IR: state_next = tms ? YCR1_TAP_STATE_EXIT2_IR : YCR1_TAP_STATE_PAUSE_IR;
        YCR1_TAP_STATE_EXIT2_IR: state_next = tms ? YCR1_TAP_STATE_UPD_IR   : YCR1_TAP_STATE_SHIFT_IR;
        YCR1_TAP_STATE_UPD_IR:   state_next = tms ? YCR1_TAP_STATE_SEL_DR   : YCR1_TAP_STATE_RTI;
        default:                 state_next = YCR1_TAP_STATE_TLR;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ycr1_tapc_fsm.sv
// ycr1_tapc_fsm
// JTAG TAP controller front-end in the core clock domain. Consumes TCK edge
// strobes plus TMS/TDI, holds the 5-bit IR and the IDCODE/BYPASS registers,
// and drives the DMI chain interface.
// Ports:
//   clk, rst                 - core clock, synchronous active-high reset
//   tck_rise_i, tck_fall_i   - one-clk TCK edge strobes
//   tms_i, tdi_i             - JTAG inputs, valid with tck_rise_i
//   tdo_o, tdo_en_o          - TDO data and enable, updated on tck_fall_i
//   tapc2dmi_ch_*            - chain select/id and capture/shift/update strobes
//   dmi2tapc_ch_tdo_i        - chain LSB returned by the DMI
module ycr1_tapc_fsm
  import ycr1_tap_pkg::*;
#(
  parameter logic [31:0] YCR1_TAP_IDCODE = YCR1_TAP_IDCODE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tck_rise_i,
  input  logic       tck_fall_i,
  input  logic       tms_i,
  input  logic       tdi_i,
  output logic       tdo_o,
  output logic       tdo_en_o,
  output logic       tapc2dmi_ch_sel_o,
  output logic [1:0] tapc2dmi_ch_id_o,
  output logic       tapc2dmi_ch_capture_o,
  output logic       tapc2dmi_ch_shift_o,
  output logic       tapc2dmi_ch_update_o,
  output logic       tapc2dmi_ch_tdi_o,
  input  logic       dmi2tapc_ch_tdo_i
);

  logic [3:0]                   state_raw;
  type_ycr1_tap_state_e         state;
  logic [YCR1_TAP_IR_WIDTH-1:0] ir;
  logic [YCR1_TAP_IR_WIDTH-1:0] ir_shift;
  logic [31:0]                  idcode_shift;
  logic                         bypass_ff;
  logic                         ir_dtmcs;
  logic                         ir_dmi;
  logic                         ir_idcode;

  ycr1_tap_fsm_core u_fsm_core (
    .clk   (clk),
    .rst   (rst),
    .adv   (tck_rise_i),
    .tms   (tms_i),
    .state (state_raw)
  );

  assign state = type_ycr1_tap_state_e'(state_raw);

  // Undefined opcodes fall through to BYPASS because none of these match.
  always_comb begin
    ir_dtmcs  = (ir == YCR1_TAP_INSTR_DTMCS);
    ir_dmi    = (ir == YCR1_TAP_INSTR_DMI_ACCESS);
    ir_idcode = (ir == YCR1_TAP_INSTR_IDCODE);
  end

  // IR and DR shift paths act on the state seen before the TCK edge moves
  // the FSM. The TLR override is last so it wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir           <= YCR1_TAP_INSTR_IDCODE;
      ir_shift     <= '0;
      idcode_shift <= '0;
      bypass_ff    <= 1'b0;
    end else begin
      if (tck_rise_i) begin
        case (state)
          YCR1_TAP_STATE_CAP_IR:   ir_shift <= 5'b00001;
          YCR1_TAP_STATE_SHIFT_IR: ir_shift <= {tdi_i, ir_shift[YCR1_TAP_IR_WIDTH-1:1]};
          YCR1_TAP_STATE_UPD_IR:   ir       <= ir_shift;
          YCR1_TAP_STATE_CAP_DR: begin
            idcode_shift <= YCR1_TAP_IDCODE;
            bypass_ff    <= 1'b0;
          end
          YCR1_TAP_STATE_SHIFT_DR: begin
            idcode_shift <= {tdi_i, idcode_shift[31:1]};
            bypass_ff    <= tdi_i;
          end
          default: ;
        endcase
      end
      if (state == YCR1_TAP_STATE_TLR) begin
        ir <= YCR1_TAP_INSTR_IDCODE;
      end
    end
  end

  // Chain select is a registered decode of the IR so the DMI sees a stable
  // value that only moves after an IR update.
  always_ff @(posedge clk) begin
    if (rst) begin
      tapc2dmi_ch_sel_o <= 1'b0;
      tapc2dmi_ch_id_o  <= 2'd0;
    end else begin
      tapc2dmi_ch_sel_o <= ir_dtmcs | ir_dmi;
      tapc2dmi_ch_id_o  <= ir_dtmcs ? YCR1_DBG_DMI_CH_ID_DTMCS :
                           ir_dmi   ? YCR1_DBG_DMI_CH_ID_DMI   : 2'd0;
    end
  end

  // Strobes are one clk wide; the states are mutually exclusive so at most
  // one strobe can fire. ch_tdi only moves together with a shift strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tapc2dmi_ch_capture_o <= 1'b0;
      tapc2dmi_ch_shift_o   <= 1'b0;
      tapc2dmi_ch_update_o  <= 1'b0;
      tapc2dmi_ch_tdi_o     <= 1'b0;
    end else begin
      tapc2dmi_ch_capture_o <= tck_rise_i & tapc2dmi_ch_sel_o & (state == YCR1_TAP_STATE_CAP_DR);
      tapc2dmi_ch_shift_o   <= tck_rise_i & tapc2dmi_ch_sel_o & (state == YCR1_TAP_STATE_SHIFT_DR);
      tapc2dmi_ch_update_o  <= tck_rise_i & tapc2dmi_ch_sel_o & (state == YCR1_TAP_STATE_UPD_DR);
      if (tck_rise_i && tapc2dmi_ch_sel_o && (state == YCR1_TAP_STATE_SHIFT_DR)) begin
        tapc2dmi_ch_tdi_o <= tdi_i;
      end
    end
  end

  // TDO moves on the falling TCK edge; a fall that coincides with a rise is
  // a protocol violation and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdo_o    <= 1'b0;
      tdo_en_o <= 1'b0;
    end else if (tck_fall_i && !tck_rise_i) begin
      case (state)
        YCR1_TAP_STATE_SHIFT_IR: begin
          tdo_o    <= ir_shift[0];
          tdo_en_o <= 1'b1;
        end
        YCR1_TAP_STATE_SHIFT_DR: begin
          tdo_o    <= (ir_dtmcs | ir_dmi) ? dmi2tapc_ch_tdo_i :
                      ir_idcode           ? idcode_shift[0]   : bypass_ff;
          tdo_en_o <= 1'b1;
        end
        default: begin
          tdo_o    <= 1'b0;
          tdo_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ycr1_tapc_fsm.sv
// tb_ycr1_tapc_fsm
// Randomized and directed bench for ycr1_tapc_fsm against a behavioural TAP
// model built from named states, a transition table and bit queues.
module tb_ycr1_tapc_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       tck_rise_i, tck_fall_i, tms_i, tdi_i, dmi2tapc_ch_tdo_i;
  logic       tdo_o, tdo_en_o;
  logic       ch_sel, ch_capture, ch_shift, ch_update, ch_tdi;
  logic [1:0] ch_id;

  ycr1_tapc_fsm dut (
    .clk                   (clk),
    .rst                   (rst),
    .tck_rise_i            (tck_rise_i),
    .tck_fall_i            (tck_fall_i),
    .tms_i                 (tms_i),
    .tdi_i                 (tdi_i),
    .tdo_o                 (tdo_o),
    .tdo_en_o              (tdo_en_o),
    .tapc2dmi_ch_sel_o     (ch_sel),
    .tapc2dmi_ch_id_o      (ch_id),
    .tapc2dmi_ch_capture_o (ch_capture),
    .tapc2dmi_ch_shift_o   (ch_shift),
    .tapc2dmi_ch_update_o  (ch_update),
    .tapc2dmi_ch_tdi_o     (ch_tdi),
    .dmi2tapc_ch_tdo_i     (dmi2tapc_ch_tdo_i)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Behavioural model
  string       nxt0 [string];
  string       nxt1 [string];
  string       mState;
  logic [4:0]  mIr;
  bit          irQ[$];
  bit          drQ[$];
  bit          mTdo, mTdoEn;
  bit          expCap, expShift, expUpd, expTdi;
  logic [31:0] idcodeValue = 32'hDEB01001;
  int          capSeen, shiftSeen, updSeen;
  bit          lastTdo;

  task automatic addEdge(input string s, input string on0, input string on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  function automatic bit isChain(input logic [4:0] code);
    return (code == 5'h10) || (code == 5'h11);
  endfunction

  function automatic logic [1:0] chainId(input logic [4:0] code);
    return (code == 5'h10) ? 2'd1 : (code == 5'h11) ? 2'd2 : 2'd0;
  endfunction

  task automatic modelReset();
    mState = "TLR";
    mIr    = 5'h01;
    mTdo   = 1'b0;
    mTdoEn = 1'b0;
    irQ.delete();
    drQ.delete();
  endtask

  task automatic modelRise(input bit tms, input bit tdi);
    bit chain;
    chain    = isChain(mIr);
    expCap   = chain && (mState == "CAPDR");
    expShift = chain && (mState == "SHDR");
    expUpd   = chain && (mState == "UPDR");
    if (expShift) expTdi = tdi;
    if (mState == "CAPIR") begin
      irQ.delete();
      irQ.push_back(1'b1);
      repeat (4) irQ.push_back(1'b0);
    end else if (mState == "SHIR") begin
      void'(irQ.pop_front());
      irQ.push_back(tdi);
    end else if (mState == "UPIR") begin
      for (int i = 0; i < 5; i++) mIr[i] = irQ[i];
    end else if (mState == "CAPDR") begin
      drQ.delete();
      if (mIr == 5'h01) begin
        for (int i = 0; i < 32; i++) drQ.push_back(idcodeValue[i]);
      end else if (!chain) begin
        drQ.push_back(1'b0);
      end
    end else if (mState == "SHDR" && !chain) begin
      void'(drQ.pop_front());
      drQ.push_back(tdi);
    end
    mState = tms ? nxt1[mState] : nxt0[mState];
    if (mState == "TLR") mIr = 5'h01;
  endtask

  task automatic modelFall(input bit dmi);
    if (mState == "SHIR") begin
      mTdo = irQ[0]; mTdoEn = 1'b1;
    end else if (mState == "SHDR") begin
      mTdo = isChain(mIr) ? dmi : drQ[0]; mTdoEn = 1'b1;
    end else begin
      mTdo = 1'b0; mTdoEn = 1'b0;
    end
  endtask

  // One TCK period: rise (optionally colliding with a fall), settle, fall.
  task automatic applyStimulus(input bit tms, input bit tdi, input bit both, input bit dmi);
    @(negedge clk);
    tms_i = tms; tdi_i = tdi; dmi2tapc_ch_tdo_i = dmi;
    tck_rise_i = 1'b1; tck_fall_i = both;
    modelRise(tms, tdi);
    @(negedge clk);
    tck_rise_i = 1'b0; tck_fall_i = 1'b0;
    capSeen += ch_capture; shiftSeen += ch_shift; updSeen += ch_update;
    checkOutput("capture", ch_capture, expCap);
    checkOutput("shift", ch_shift, expShift);
    checkOutput("update", ch_update, expUpd);
    if (expShift) checkOutput("ch_tdi", ch_tdi, expTdi);
    @(negedge clk);
    capSeen += ch_capture; shiftSeen += ch_shift; updSeen += ch_update;
    checkOutput("strobe_width", {ch_capture, ch_shift, ch_update}, 3'b000);
    @(negedge clk);
    checkOutput("ch_sel", ch_sel, isChain(mIr));
    checkOutput("ch_id", ch_id, chainId(mIr));
    checkOutput("tdo_hold", {tdo_en_o, tdo_o}, {mTdoEn, mTdo});
    if (!both) begin
      tck_fall_i = 1'b1;
      modelFall(dmi);
      @(negedge clk);
      tck_fall_i = 1'b0;
      checkOutput("tdo", tdo_o, mTdo);
      checkOutput("tdo_en", tdo_en_o, mTdoEn);
      checkOutput("strobe_idle", {ch_capture, ch_shift, ch_update}, 3'b000);
    end
    lastTdo = tdo_o;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; tck_rise_i = 1'b0; tck_fall_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("rst_tdo", {tdo_en_o, tdo_o}, 2'b00);
    checkOutput("rst_strobes", {ch_capture, ch_shift, ch_update, ch_tdi}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ch_sel", {ch_sel, ch_id}, 3'b000);
  endtask

  task automatic tapReset();
    repeat (5) applyStimulus(1'b1, $urandom_range(0, 1), 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // From RTI; returns the five bits shifted out of the IR
  task automatic loadIr(input logic [4:0] code, output logic [4:0] outBits);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    outBits[0] = lastTdo;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 4, code[i], 1'b0, 1'b0);
      if (i < 4) outBits[i+1] = lastTdo;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // From RTI; shifts n bits of tdiVec and collects the TDO stream
  task automatic drScan(input int n, input logic [63:0] tdiVec, output logic [63:0] tdoVec);
    tdoVec = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
    tdoVec[0] = lastTdo;
    for (int i = 0; i < n; i++) begin
      applyStimulus(i == n - 1, tdiVec[i], 1'b0, $urandom_range(0, 1));
      if (i < n - 1) tdoVec[i+1] = lastTdo;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clearCounts();
    capSeen = 0; shiftSeen = 0; updSeen = 0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, checks so far %0d", checkCount);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [4:0]  irOut;
    logic [63:0] tdoVec;
    logic [63:0] tdiVec;
    logic [4:0]  codes [6];

    addEdge("TLR",   "RTI",   "TLR");
    addEdge("RTI",   "RTI",   "SELDR");
    addEdge("SELDR", "CAPDR", "SELIR");
    addEdge("CAPDR", "SHDR",  "EX1DR");
    addEdge("SHDR",  "SHDR",  "EX1DR");
    addEdge("EX1DR", "PDR",   "UPDR");
    addEdge("PDR",   "PDR",   "EX2DR");
    addEdge("EX2DR", "SHDR",  "UPDR");
    addEdge("UPDR",  "RTI",   "SELDR");
    addEdge("SELIR", "CAPIR", "TLR");
    addEdge("CAPIR", "SHIR",  "EX1IR");
    addEdge("SHIR",  "SHIR",  "EX1IR");
    addEdge("EX1IR", "PIR",   "UPIR");
    addEdge("PIR",   "PIR",   "EX2IR");
    addEdge("EX2IR", "SHIR",  "UPIR");
    addEdge("UPIR",  "RTI",   "SELDR");
    codes[0] = 5'h01; codes[1] = 5'h10; codes[2] = 5'h11;
    codes[3] = 5'h1F; codes[4] = 5'h07; codes[5] = 5'h00;

    rst = 1'b1; tck_rise_i = 1'b0; tck_fall_i = 1'b0;
    tms_i = 1'b0; tdi_i = 1'b0; dmi2tapc_ch_tdo_i = 1'b0;
    clearCounts();
    repeat (3) @(negedge clk);
    applyReset();

    // IDCODE readout after TMS reset
    tapReset();
    clearCounts();
    drScan(32, {$urandom, $urandom}, tdoVec);
    checkOutput("idcode_stream", tdoVec[31:0], 32'hDEB01001);
    checkOutput("idcode_no_strobes", capSeen + shiftSeen + updSeen, 0);

    // BYPASS: IR capture pattern and one-TCK TDI delay
    loadIr(5'h1F, irOut);
    checkOutput("ir_capture", irOut, 5'b00001);
    drScan(4, 64'b1101, tdoVec);
    checkOutput("bypass_stream", tdoVec[3:0], 4'b1010);

    // DMI_ACCESS chain scan of 41 bits
    loadIr(5'h11, irOut);
    clearCounts();
    drScan(41, {$urandom, $urandom}, tdoVec);
    checkOutput("dmi_cap_count", capSeen, 1);
    checkOutput("dmi_shift_count", shiftSeen, 41);
    checkOutput("dmi_upd_count", updSeen, 1);
    checkOutput("dmi_ch_sel", {ch_sel, ch_id}, 3'b110);

    // DTMCS chain: TDO follows the randomly toggled chain TDO
    loadIr(5'h10, irOut);
    drScan(32, {$urandom, $urandom}, tdoVec);
    checkOutput("dtmcs_ch_sel", {ch_sel, ch_id}, 3'b101);

    // Reset in the middle of a chain shift
    loadIr(5'h11, irOut);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) applyStimulus(1'b0, $urandom_range(0, 1), 1'b0, 1'b0);
    clearCounts();
    applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_no_update", updSeen, 0);
    drScan(32, {$urandom, $urandom}, tdoVec);
    checkOutput("midrst_idcode", tdoVec[31:0], 32'hDEB01001);

    // Undefined opcode acts as BYPASS without touching the DMI
    loadIr(5'h07, irOut);
    clearCounts();
    drScan(8, 64'hA5, tdoVec);
    checkOutput("undef_bypass", tdoVec[7:0], 8'h4A);
    checkOutput("undef_no_strobes", capSeen + shiftSeen + updSeen, 0);

    // Random walk mixing raw TCK steps, collisions, IR loads, scans, resets
    for (int it = 0; it < 500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        applyReset();
      end else if (r < 10) begin
        tapReset();
        if ($urandom_range(0, 3) == 0) loadIr(5'($urandom), irOut);
        else loadIr(codes[$urandom_range(0, 5)], irOut);
        drScan($urandom_range(1, 20), {$urandom, $urandom}, tdoVec);
      end else begin
        applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1),
                      $urandom_range(0, 39) == 0, $urandom_range(0, 1));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
